// File: rtl/ybus_row_scheduler_if.sv
// Handshake/bus bundle between the row scheduler, the global buffer read
// port and the X-bus controllers. The scheduler uses the master modport and
// the surrounding logic uses the slave modport.
interface ybus_row_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int BURST_MAX  = 256
);
  localparam int TAG_W = $clog2(NUM_ROW);
  localparam int LEN_W = $clog2(BURST_MAX + 1);

  logic                  start;
  logic [TAG_W-1:0]      row_first;
  logic [TAG_W-1:0]      row_last;
  logic [LEN_W-1:0]      burst_len;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic                  flush;
  logic [TAG_W-1:0]      y_tag;
  logic                  bus_valid;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  bus_ready;
  logic                  busy;
  logic                  done;
  logic [31:0]           stall_cnt;

  modport master (
    input  start, row_first, row_last, burst_len,
    input  src_valid, src_data, bus_ready,
    output src_ready, flush, y_tag, bus_valid, bus_data,
    output busy, done, stall_cnt
  );

  modport slave (
    output start, row_first, row_last, burst_len,
    output src_valid, src_data, bus_ready,
    input  src_ready, flush, y_tag, bus_valid, bus_data,
    input  busy, done, stall_cnt
  );
endinterface

// File: rtl/ybus_row_scheduler.sv
// ybus_row_scheduler: walks a configured range of PE rows, broadcasting each
// row tag with a flush pulse, waiting one settle cycle, then streaming
// burst_len global-buffer words onto the shared row bus through a single
// output register.
// Optional feature macro: YBUS_STALL_CNT_EN (bus back-pressure cycle counter).
module ybus_row_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int NUM_COL    = 4,
  parameter int BURST_MAX  = 256
) (
  input  logic clk,
  input  logic rstn,
  ybus_row_scheduler_if.master bus_if
);
  localparam int TAG_W = $clog2(NUM_ROW);
  localparam int LEN_W = $clog2(BURST_MAX + 1);

  if (NUM_ROW < 2 || NUM_COL < 1) begin : g_bad_cfg
    $error("ybus_row_scheduler: NUM_ROW must be >= 2 and NUM_COL >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_SETTLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [TAG_W-1:0]      r_row;
  logic [TAG_W-1:0]      r_row_last;
  logic [LEN_W-1:0]      r_burst_len;
  logic [LEN_W-1:0]      r_word_cnt;
  logic                  r_flush;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_bus_valid;
  logic [DATA_WIDTH-1:0] r_bus_data;

  logic                  w_bus_free;
  logic                  w_src_ready;
  logic                  w_accept;
  logic [LEN_W-1:0]      w_cnt_inc;
  logic                  w_last_word;
  logic [TAG_W-1:0]      w_row_next;

  // Handshake decode: output register free, source acceptance, row wrap
  always_comb begin
    w_bus_free  = !r_bus_valid || bus_if.bus_ready;
    w_src_ready = (r_state == S_STREAM) && (r_word_cnt < r_burst_len) && w_bus_free;
    w_accept    = w_src_ready && bus_if.src_valid;
    w_cnt_inc   = r_word_cnt + 1'b1;
    w_last_word = (w_cnt_inc == r_burst_len);
    w_row_next  = (r_row == TAG_W'(NUM_ROW - 1)) ? '0 : r_row + 1'b1;
  end

  // Row sequencing FSM with registered flush/done/busy and latched pass config
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_row_last  <= '0;
      r_burst_len <= '0;
      r_word_cnt  <= '0;
      r_flush     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus_if.start) begin
            r_row       <= bus_if.row_first;
            r_row_last  <= bus_if.row_last;
            r_burst_len <= bus_if.burst_len;
            r_word_cnt  <= '0;
            r_flush     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_TAG;
          end
        end
        S_TAG: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          r_state <= (r_burst_len == '0) ? S_DRAIN : S_STREAM;
        end
        S_STREAM: begin
          if (w_accept) begin
            r_word_cnt <= w_cnt_inc;
            if (w_last_word) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_bus_free) begin
            if (r_row == r_row_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_row      <= w_row_next;
              r_word_cnt <= '0;
              r_flush    <= 1'b1;
              r_state    <= S_TAG;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Single output register: load on source accept, clear when the bus takes it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
    end else if (w_accept) begin
      r_bus_valid <= 1'b1;
      r_bus_data  <= bus_if.src_data;
    end else if (bus_if.bus_ready) begin
      r_bus_valid <= 1'b0;
    end
  end

`ifdef YBUS_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles the row bus holds a word it cannot deliver
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_IDLE && bus_if.start) begin
      r_stall_cnt <= '0;
    end else if (r_bus_valid && !bus_if.bus_ready && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus_if.stall_cnt = r_stall_cnt;
`else
  assign bus_if.stall_cnt = '0;
`endif

  assign bus_if.src_ready = w_src_ready;
  assign bus_if.flush     = r_flush;
  assign bus_if.y_tag     = r_row;
  assign bus_if.bus_valid = r_bus_valid;
  assign bus_if.bus_data  = r_bus_data;
  assign bus_if.busy      = r_busy;
  assign bus_if.done      = r_done;
endmodule

// File: tb/tb_ybus_row_scheduler.sv
// Directed testbench for ybus_row_scheduler (NUM_ROW=4, DATA_WIDTH=16).
// The source supplies 16'h1000 + n for the n-th accepted word.
module tb_ybus_row_scheduler;
  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  ybus_row_scheduler_if #(.DATA_WIDTH(16), .NUM_ROW(4), .BURST_MAX(256)) yb ();

  ybus_row_scheduler #(
    .DATA_WIDTH(16),
    .NUM_ROW   (4),
    .NUM_COL   (4),
    .BURST_MAX (256)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus_if(yb)
  );

  int n_checks = 0;
  int n_errors = 0;

  int         src_idx = 0;
  bit         src_take = 1'b0;
  logic [1:0] tags_q[$];
  logic [15:0] words_q[$];
  int         stab_err = 0;
  int         sr_in_stall = 0;
  int         sr_seen = 0;
  int         bv_seen = 0;
  int         done_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  assign yb.src_data = 16'h1000 + src_idx[15:0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mid-cycle observation of every handshake the DUT presents
  always @(negedge clk) begin
    if (yb.flush) tags_q.push_back(yb.y_tag);
    if (yb.bus_valid && yb.bus_ready) words_q.push_back(yb.bus_data);
    if (prev_stall && yb.bus_valid && yb.bus_data !== prev_data) stab_err++;
    prev_stall = yb.bus_valid && !yb.bus_ready;
    prev_data  = yb.bus_data;
    if (yb.src_ready && yb.bus_valid && !yb.bus_ready) sr_in_stall++;
    if (yb.src_ready) sr_seen++;
    if (yb.bus_valid) bv_seen++;
    if (yb.done) done_cnt++;
    src_take = yb.src_valid && yb.src_ready;
  end

  // Advance the source word on the edge that consumes it
  always @(posedge clk) begin
    if (src_take) src_idx <= src_idx + 1;
  end

  task automatic start_pass(input int first, input int last, input int len);
    @(posedge clk); #1;
    yb.row_first = 2'(first);
    yb.row_last  = 2'(last);
    yb.burst_len = 9'(len);
    yb.start     = 1'b1;
    @(posedge clk); #1;
    yb.start     = 1'b0;
    yb.row_first = 2'(~first);
    yb.row_last  = 2'(~last);
    yb.burst_len = 9'd7;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk); #1;
      if (yb.done) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_tags(input string tag, input int t0, input int first, input int n);
    check_eq({tag, "_ntags"}, 32'(tags_q.size() - t0), 32'(n));
    for (int k = 0; k < n; k++) begin
      check_eq({tag, "_tag"},
               (t0 + k < tags_q.size()) ? 32'(tags_q[t0 + k]) : 32'hDEAD_BEEF,
               32'((first + k) % 4));
    end
  endtask

  task automatic check_words(input string tag, input int w0, input int base, input int n);
    check_eq({tag, "_nwords"}, 32'(words_q.size() - w0), 32'(n));
    for (int k = 0; k < n; k++) begin
      check_eq({tag, "_word"},
               (w0 + k < words_q.size()) ? 32'(words_q[w0 + k]) : 32'hDEAD_BEEF,
               32'(16'h1000 + 16'(base + k)));
    end
  endtask

  initial begin
    int t0, w0, base, d0, s0, b0;
    bit seen;

    yb.start     = 1'b0;
    yb.row_first = '0;
    yb.row_last  = '0;
    yb.burst_len = '0;
    yb.src_valid = 1'b1;
    yb.bus_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",  32'(yb.busy), 32'd0);
    check_eq("rst_flush", 32'(yb.flush), 32'd0);
    check_eq("rst_bv",    32'(yb.bus_valid), 32'd0);
    check_eq("rst_sr",    32'(yb.src_ready), 32'd0);
    check_eq("rst_stall", yb.stall_cnt, 32'd0);
    rstn = 1'b1;

    // T1: rows 0..3, 4 words each, no back-pressure; cycle-exact head of pass
    t0 = tags_q.size(); w0 = words_q.size(); base = src_idx; d0 = done_cnt;
    start_pass(0, 3, 4);
    check_eq("t1_c1_flush", 32'(yb.flush), 32'd1);
    check_eq("t1_c1_tag",   32'(yb.y_tag), 32'd0);
    check_eq("t1_c1_busy",  32'(yb.busy), 32'd1);
    @(posedge clk); #1;
    check_eq("t1_c2_flush", 32'(yb.flush), 32'd0);
    check_eq("t1_c2_sr",    32'(yb.src_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("t1_c3_sr",    32'(yb.src_ready), 32'd1);
    wait_done("t1_done");
    check_eq("t1_busy_at_done", 32'(yb.busy), 32'd1);
    @(negedge clk); #1;
    check_eq("t1_busy_after", 32'(yb.busy), 32'd0);
    check_eq("t1_done_width", 32'(yb.done), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_tags("t1", t0, 0, 4);
    check_words("t1", w0, base, 16);
    check_eq("t1_last_tag", 32'(yb.y_tag), 32'd3);

    // T2: wrap-around rows 3 -> 0 -> 1
    t0 = tags_q.size(); w0 = words_q.size(); base = src_idx;
    start_pass(3, 1, 2);
    wait_done("t2_done");
    repeat (2) @(negedge clk);
    check_tags("t2", t0, 3, 3);
    check_words("t2", w0, base, 6);

    // T3: bus held off for 5 cycles after the first word appears
    t0 = tags_q.size(); w0 = words_q.size(); base = src_idx; s0 = sr_in_stall;
    @(posedge clk); #1;
    yb.bus_ready = 1'b0;
    start_pass(0, 0, 3);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (yb.bus_valid) seen = 1'b1;
    end
    check_eq("t3_first_bv", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    yb.bus_ready = 1'b1;
    wait_done("t3_done");
    repeat (2) @(negedge clk);
    check_words("t3", w0, base, 3);
    check_eq("t3_stable", 32'(stab_err), 32'd0);
    check_eq("t3_sr_stall", 32'(sr_in_stall - s0), 32'd0);
`ifdef YBUS_STALL_CNT_EN
    check_eq("t3_stall_cnt", yb.stall_cnt, 32'd5);
`else
    check_eq("t3_stall_cnt", yb.stall_cnt, 32'd0);
`endif

    // T4: zero-length rows still flush tags but never move data
    t0 = tags_q.size(); w0 = words_q.size(); d0 = done_cnt; s0 = sr_seen; b0 = bv_seen;
    start_pass(1, 2, 0);
    wait_done("t4_done");
    repeat (2) @(negedge clk);
    check_tags("t4", t0, 1, 2);
    check_eq("t4_no_bv", 32'(bv_seen - b0), 32'd0);
    check_eq("t4_no_sr", 32'(sr_seen - s0), 32'd0);
    check_eq("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // T5: asynchronous reset while row 1 is streaming
    start_pass(0, 3, 4);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (yb.flush && yb.y_tag == 2'd1) seen = 1'b1;
    end
    check_eq("t5_row1_tag", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t5_pre_bv",   32'(yb.bus_valid), 32'd1);
    check_eq("t5_pre_busy", 32'(yb.busy), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check_eq("t5_rst_bv",    32'(yb.bus_valid), 32'd0);
    check_eq("t5_rst_data",  32'(yb.bus_data), 32'd0);
    check_eq("t5_rst_tag",   32'(yb.y_tag), 32'd0);
    check_eq("t5_rst_busy",  32'(yb.busy), 32'd0);
    check_eq("t5_rst_sr",    32'(yb.src_ready), 32'd0);
    check_eq("t5_rst_flush", 32'(yb.flush), 32'd0);
    check_eq("t5_rst_done",  32'(yb.done), 32'd0);
    check_eq("t5_rst_stall", yb.stall_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(negedge clk);
    t0 = tags_q.size(); w0 = words_q.size(); base = src_idx;
    start_pass(0, 0, 1);
    wait_done("t5_done");
    repeat (2) @(negedge clk);
    check_tags("t5", t0, 0, 1);
    check_words("t5", w0, base, 1);

    // T6: second start during a pass must not change the latched range
    t0 = tags_q.size(); w0 = words_q.size(); base = src_idx; d0 = done_cnt;
    start_pass(0, 1, 2);
    repeat (3) @(posedge clk);
    #1;
    yb.row_first = 2'd2;
    yb.row_last  = 2'd3;
    yb.burst_len = 9'd5;
    yb.start     = 1'b1;
    @(posedge clk); #1;
    yb.start     = 1'b0;
    wait_done("t6_done");
    repeat (3) @(negedge clk);
    check_tags("t6", t0, 0, 2);
    check_words("t6", w0, base, 4);
    check_eq("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("t6_idle",     32'(yb.busy), 32'd0);
    check_eq("t6_tag_hold", 32'(yb.y_tag), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
